// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the programmable serial pattern detector.
// Reset defaults describe a 1101 detector with overlap enabled.
package seq_det_pkg;

  localparam int MAX_PAT_W = 32;
  localparam int DEF_PAT_W = 8;
  localparam logic [DEF_PAT_W-1:0] DEF_PATTERN_C = 8'b0000_1101;
  localparam int DEF_LEN_C = 4;
  localparam bit DEF_OVERLAP_C = 1'b1;

  function automatic int len_w(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

  // Ones in the low 'len' positions: the bits that take part in a compare.
  function automatic logic [MAX_PAT_W-1:0] len_mask(input int len);
    logic [MAX_PAT_W-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_PAT_W; i++) begin
      m[i] = (i < len);
    end
    return m;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up counter that sticks at all-ones; clear wins over increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-programmable serial pattern detector with Mealy match output,
// selectable overlap mode and a saturating match counter.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int               PAT_W       = DEF_PAT_W,
  parameter int               CNT_W       = 8,
  parameter logic [PAT_W-1:0] DEF_PATTERN = PAT_W'(DEF_PATTERN_C),
  parameter int               DEF_LEN     = DEF_LEN_C,
  parameter bit               DEF_OVERLAP = DEF_OVERLAP_C,
  localparam int              LEN_W       = len_w(PAT_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  input  logic             in_valid,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic             cnt_clr,
  output logic             out,
  output logic             cfg_err,
  output logic [CNT_W-1:0] match_cnt
);

  localparam logic [LEN_W-1:0] PAT_W_L = LEN_W'(PAT_W);

  logic [PAT_W-1:0] r_pat;
  logic [LEN_W-1:0] r_len;
  logic             r_ovl;
  // The oldest history bit is shifted out before it can ever be compared.
  logic [PAT_W-2:0] r_hist;
  logic [LEN_W-1:0] r_fill;
  logic             r_cfg_err;

  logic [PAT_W-1:0] w_cand;
  logic [PAT_W-1:0] w_mask;
  logic [PAT_W-1:0] w_bit_ok;
  logic             w_filled;
  logic             w_accept;
  logic             w_len_ok;

  assign w_cand   = {r_hist, in};
  assign w_mask   = PAT_W'(len_mask(int'(r_len)));
  assign w_filled = ({1'b0, r_fill} + (LEN_W + 1)'(1)) >= {1'b0, r_len};
  assign w_accept = in_valid & ~cfg_load & ~rst;
  assign w_len_ok = (cfg_len != '0) && (cfg_len <= PAT_W_L);

  for (genvar gi = 0; gi < PAT_W; gi++) begin : g_cmp
    assign w_bit_ok[gi] = ~w_mask[gi] | (w_cand[gi] == r_pat[gi]);
  end

  assign out = w_accept & w_filled & (&w_bit_ok);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pat     <= DEF_PATTERN;
      r_len     <= LEN_W'(DEF_LEN);
      r_ovl     <= DEF_OVERLAP;
      r_hist    <= '0;
      r_fill    <= '0;
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= cfg_load & ~w_len_ok;
      if (cfg_load) begin
        if (w_len_ok) begin
          r_pat  <= cfg_pattern;
          r_len  <= cfg_len;
          r_ovl  <= cfg_overlap;
          r_hist <= '0;
          r_fill <= '0;
        end
      end else if (in_valid) begin
        r_hist <= w_cand[PAT_W-2:0];
        if (out && !r_ovl) begin
          r_fill <= '0;
        end else if (r_fill != PAT_W_L) begin
          r_fill <= r_fill + 1'b1;
        end
      end
    end
  end

  assign cfg_err = r_cfg_err;

  sat_counter #(
    .W(CNT_W)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (out),
    .cnt (match_cnt)
  );

endmodule
